// File: rtl/posit_mult_flow_ctrl_n32_pkg.sv
// Shared constants and result-entry layout for the posit multiplier flow-control slice.
package posit_mult_flow_ctrl_n32_pkg;

  localparam int unsigned POSIT_N         = 32;
  localparam int unsigned POSIT_ES        = 6;
  localparam int unsigned MUL_LAT_DEFAULT = 5;

  typedef struct packed {
    logic                inf;
    logic                zero;
    logic [POSIT_N-1:0]  data;
  } res_entry_t;

  localparam int unsigned RES_W = $bits(res_entry_t);

endpackage

// File: rtl/posit_mult_flow_ctrl_n32_res_fifo.sv
// Show-ahead result FIFO; the storage array is not reset, only pointers and count.
module posit_res_fifo
  import posit_mult_flow_ctrl_n32_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  res_entry_t wr_data,
  input  logic       rd_en,
  output res_entry_t rd_data,
  output logic [AW:0] count
);

  res_entry_t        mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/posit_mult_flow_ctrl_n32.sv
// Valid/ready wrapper around a fixed-latency, stall-free posit multiplier with a credit-guarded result FIFO.
module posit_mult_flow_ctrl_n32
  import posit_mult_flow_ctrl_n32_pkg::*;
#(
  parameter int unsigned N       = POSIT_N,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT,
  parameter int unsigned AW      = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] mul_in1,
  output logic [N-1:0] mul_in2,
  output logic         mul_start,
  input  logic [N-1:0] mul_out,
  input  logic         mul_inf,
  input  logic         mul_zero,
  input  logic         mul_done,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [N-1:0] res_data,
  output logic         res_inf,
  output logic         res_zero,
  output logic [AW:0]  occupancy,
  output logic         err_done
);

  localparam int unsigned DW = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT + 1);

  logic [DW-1:0] drain_cnt;
  logic [AW:0]   count;
  logic [AW:0]   inflight;
  logic [AW+1:0] used;
  logic          draining;
  logic          issue;
  logic          done_ok;
  logic          retire;
  logic          wr_en;
  logic          rd_en;
  res_entry_t    wr_entry;
  res_entry_t    rd_entry;

  assign draining  = (drain_cnt != '0);
  assign used      = {1'b0, count} + {1'b0, inflight};
  assign in_ready  = !draining && (used < (AW+2)'(DEPTH));
  assign issue     = in_valid && in_ready;
  assign done_ok   = mul_done && !draining;
  // A done with nothing in flight only retires a credit if an issue refills it this cycle (saturate at 0).
  assign retire    = done_ok && ((inflight != '0) || issue);
  assign wr_en     = done_ok && (count < (AW+1)'(DEPTH));
  assign res_valid = (count != '0);
  assign rd_en     = res_valid && res_ready;

  assign mul_start = issue;
  assign mul_in1   = in_a;
  assign mul_in2   = in_b;
  assign wr_entry  = {mul_inf, mul_zero, mul_out};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt <= DW'(MUL_LAT);
      inflight  <= '0;
      err_done  <= 1'b0;
    end else begin
      if (draining) drain_cnt <= drain_cnt - 1'b1;
      case ({issue, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (done_ok && (inflight == '0)) err_done <= 1'b1;
    end
  end

  posit_res_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_res_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_entry),
    .rd_en   (rd_en),
    .rd_data (rd_entry),
    .count   (count)
  );

  assign res_data  = rd_entry.data;
  assign res_inf   = rd_entry.inf;
  assign res_zero  = rd_entry.zero;
  assign occupancy = count;

endmodule

// File: tb/tb_posit_mult_flow_ctrl_n32.sv
// Scoreboard bench for posit_mult_flow_ctrl_n32 with a 5-cycle behavioural multiplier in the loop.
module tb_posit_mult_flow_ctrl_n32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [31:0] mul_in1, mul_in2;
  logic        mul_start;
  logic [31:0] mul_out;
  logic        mul_inf, mul_zero, mul_done;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        res_inf, res_zero;
  logic [3:0]  occupancy;
  logic        err_done;
  logic        force_done = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [33:0] exp_q[$];

  logic [5:1]  vpipe = '0;
  logic [33:0] dpipe [1:5];

  always #5 clk = ~clk;

  posit_mult_flow_ctrl_n32 #(
    .N       (32),
    .DEPTH   (8),
    .MUL_LAT (5),
    .AW      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_start (mul_start),
    .mul_out   (mul_out),
    .mul_inf   (mul_inf),
    .mul_zero  (mul_zero),
    .mul_done  (mul_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_inf   (res_inf),
    .res_zero  (res_zero),
    .occupancy (occupancy),
    .err_done  (err_done)
  );

  // Behavioural multiplier result {inf, zero, product}; 1.0 is the identity, other values get an asymmetric mix.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] p;
    if (a == 32'h4000_0000)      p = b;
    else if (b == 32'h4000_0000) p = a;
    else                         p = a ^ {b[15:0], b[31:16]} ^ 32'h0000_0001;
    return {(a == 32'h8000_0000) || (b == 32'h8000_0000), (a == '0) || (b == '0), p};
  endfunction

  initial for (int k = 1; k <= 5; k++) dpipe[k] = '0;

  always @(posedge clk) begin
    vpipe    <= {vpipe[4:1], mul_start};
    dpipe[1] <= model(mul_in1, mul_in2);
    for (int k = 2; k <= 5; k++) dpipe[k] <= dpipe[k-1];
  end

  assign mul_done = vpipe[5] | force_done;
  assign mul_out  = dpipe[5][31:0];
  assign mul_zero = dpipe[5][32];
  assign mul_inf  = dpipe[5][33];

  // One clock at the negedge: records accepted operands into the scoreboard and captures any handshaken result.
  task automatic tick(output bit popped, output logic [33:0] got, output bit accepted);
    popped = 1'b0; accepted = 1'b0; got = '0;
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_a, in_b));
      accepted = 1'b1;
    end
    if (res_valid && res_ready) begin
      popped = 1'b1;
      got = {res_inf, res_zero, res_data};
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    bit p, a;
    logic [33:0] g;
    res_ready = 1'b0;
    force_done = 1'b0;
    @(negedge clk);
    do_reset(2);
    for (int i = 0; i <= 5; i++) begin
      checks++;
      if (in_ready !== (i == 5)) begin
        failures++;
        $display("FAIL reset_in_ready cycle=%0d got=%b exp=%b", i, in_ready, (i == 5));
      end
      checks++;
      if (res_valid !== 1'b0 || occupancy !== 4'd0) begin
        failures++;
        $display("FAIL reset_idle cycle=%0d res_valid=%b occupancy=%0d exp 0/0", i, res_valid, occupancy);
      end
      tick(p, g, a);
    end
  endtask

  task automatic test_single_op();
    bit p, a;
    logic [33:0] g;
    in_a = 32'h4000_0000;
    in_b = 32'h4000_0000;
    in_valid = 1'b1;
    tick(p, g, a);
    in_valid = 1'b0;
    checks++;
    if (!a) begin
      failures++;
      $display("FAIL single_accept got=%b exp=1", a);
    end
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (res_valid !== 1'b0) begin
        failures++;
        $display("FAIL single_early_valid t+%0d got=%b exp=0", k, res_valid);
      end
      tick(p, g, a);
    end
    checks++;
    if (res_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency t+6 res_valid got=%b exp=1", res_valid);
    end
    res_ready = 1'b1;
    tick(p, g, a);
    res_ready = 1'b0;
    checks++;
    if (!p || g !== {2'b00, 32'h4000_0000}) begin
      failures++;
      $display("FAIL single_data popped=%b got=%h exp=%h", p, g, {2'b00, 32'h4000_0000});
    end
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic test_backpressure();
    bit p, a;
    logic [33:0] g, e;
    int accepted_n = 0;
    int got_n = 0;
    res_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_a = $urandom;
      in_b = $urandom;
      tick(p, g, a);
      if (a) accepted_n++;
    end
    in_valid = 1'b0;
    checks++;
    if (accepted_n != 8) begin
      failures++;
      $display("FAIL bp_accept_count got=%0d exp=8", accepted_n);
    end
    checks++;
    if (in_ready !== 1'b0 || occupancy !== 4'd8) begin
      failures++;
      $display("FAIL bp_full in_ready=%b occupancy=%0d exp 0/8", in_ready, occupancy);
    end
    res_ready = 1'b1;
    for (int i = 0; i < 40 && got_n < 8; i++) begin
      tick(p, g, a);
      if (p) begin
        got_n++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3_dead_beef;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL bp_order idx=%0d got=%h exp=%h", got_n - 1, g, e);
        end
      end
    end
    res_ready = 1'b0;
    checks++;
    if (got_n != 8 || occupancy !== 4'd0) begin
      failures++;
      $display("FAIL bp_drain results=%0d occupancy=%0d exp 8/0", got_n, occupancy);
    end
  endtask

  task automatic test_streaming();
    bit p, a;
    logic [33:0] g, e;
    int sent = 0;
    int rcvd = 0;
    int cyc = 0;
    in_valid = 1'b1;
    in_a = $urandom;
    in_b = $urandom;
    while ((sent < 64 || rcvd < 64) && cyc < 2000) begin
      res_ready = ($urandom_range(0, 1) == 1);
      checks++;
      if (32'(occupancy) + $countones(vpipe) > 8) begin
        failures++;
        $display("FAIL stream_credit cycle=%0d occ+inflight=%0d exp<=8", cyc, 32'(occupancy) + $countones(vpipe));
      end
      tick(p, g, a);
      cyc++;
      if (a) begin
        sent++;
        in_a = $urandom;
        in_b = $urandom;
        if (sent == 64) in_valid = 1'b0;
      end
      if (p) begin
        rcvd++;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 34'h3_dead_beef;
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL stream_data idx=%0d got=%h exp=%h", rcvd - 1, g, e);
        end
      end
    end
    in_valid = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (sent != 64 || rcvd != 64) begin
      failures++;
      $display("FAIL stream_complete sent=%0d received=%0d exp 64/64", sent, rcvd);
    end
  endtask

  task automatic test_reset_midstream();
    bit p, a;
    logic [33:0] g;
    res_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) begin
      in_a = $urandom;
      in_b = $urandom;
      tick(p, g, a);
    end
    in_valid = 1'b0;
    repeat (8) tick(p, g, a);
    checks++;
    if (occupancy !== 4'd4) begin
      failures++;
      $display("FAIL mid_setup occupancy got=%0d exp=4", occupancy);
    end
    in_valid = 1'b1;
    repeat (3) begin
      in_a = $urandom;
      in_b = $urandom;
      tick(p, g, a);
    end
    do_reset(1);
    res_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (res_valid !== 1'b0 || occupancy !== 4'd0 || err_done !== 1'b0) begin
        failures++;
        $display("FAIL mid_flush cycle=%0d res_valid=%b occupancy=%0d err_done=%b exp 0/0/0",
                 i, res_valid, occupancy, err_done);
      end
      tick(p, g, a);
    end
    res_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_ready_after_drain got=%b exp=1", in_ready);
    end
  endtask

  task automatic test_protocol_error();
    bit p, a;
    logic [33:0] g;
    checks++;
    if (err_done !== 1'b0) begin
      failures++;
      $display("FAIL err_initial got=%b exp=0", err_done);
    end
    force_done = 1'b1;
    tick(p, g, a);
    force_done = 1'b0;
    checks++;
    if (err_done !== 1'b1 || occupancy !== 4'd1) begin
      failures++;
      $display("FAIL err_set err_done=%b occupancy=%0d exp 1/1", err_done, occupancy);
    end
    res_ready = 1'b1;
    tick(p, g, a);
    res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (err_done !== 1'b1) begin
        failures++;
        $display("FAIL err_sticky cycle=%0d got=%b exp=1", i, err_done);
      end
      tick(p, g, a);
    end
    do_reset(1);
    checks++;
    if (err_done !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared_by_reset got=%b exp=0", err_done);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_streaming();
    test_reset_midstream();
    test_protocol_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
